// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and frame defaults
// used by both the receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: start-bit qualification at mid-bit, LSB-first data
// shift, configurable stop length, one-cycle done pulse and sticky frame error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err
);

  localparam int S_W = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int N_W = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic rx_s;

  state_t          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      // Falling edge is acted on immediately; the tick only paces later states.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            ferr_d  = !rx_s;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_done_tick = done_q;
  assign dout         = b_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised at 16 x 78 clk per bit from a
// 12 MHz clock; a monitor pops the expected word/frame_err on every rx_done_tick.
module tb_uart_rx;
  timeunit 1ns;
  timeprecision 1ps;
  import uart_pkg::*;

  localparam int DIV     = 78;
  localparam int BIT_CLK = OVERSAMPLE * DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  int   done_cyc = 0;
  int   tick_cnt = 0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err)
  );

  always #41.667 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick generator: one-clk pulse every DIV clocks, gateable for the stall test.
  initial begin
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == DIV - 1) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == DIV - 1) && tick_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every completed frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rx_done_tick === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: dout=0x%0h, expected no rx_done_tick", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e.data});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: reached %0d clk, expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_done);
    exp_t e;
    if (expect_done) begin
      e.data = d;
      e.ferr = !stop_bit;
      exp_q.push_back(e);
      exp_done++;
    end
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
    if (stop_bit) begin
      rx = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      // Low only past the stop-bit sample point, so the line is high again
      // before a start qualified from this low level could be accepted.
      rx = 1'b0;
      wait_clk(BIT_CLK / 2 + 300);
      rx = 1'b1;
      wait_clk(BIT_CLK / 2 - 300 + BIT_CLK);
    end
  endtask

  initial begin
    int t_start;
    int lat;
    int done_before;

    // Reset state
    wait_clk(5);
    reset = 1'b0;
    wait_clk(3);
    check("reset_dout", {24'd0, dout}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    check("reset_done", {31'd0, rx_done_tick}, 32'h0);

    // Single frame 0x55 and its latency from the start edge
    t_start = cyc;
    send_frame(8'h55, 1'b1, 1'b1);
    wait_clk(200);
    lat = done_cyc - t_start;
    n_tests++;
    if (lat < 151 * DIV || lat > 152 * DIV + 20) begin
      n_fail++;
      $display("FAIL latency_55: got %0d clk, expected %0d..%0d", lat, 151 * DIV, 152 * DIV + 20);
    end
    check("done_count_55", n_done, exp_done);

    // Back-to-back frames with no idle gap
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    wait_clk(200);
    check("done_count_b2b", n_done, exp_done);

    // False start: low for 4 ticks only
    rx = 1'b0;
    wait_clk(4 * DIV);
    rx = 1'b1;
    wait_clk(BIT_CLK + 400);
    check("glitch_done_count", n_done, exp_done);
    check("glitch_dout", {24'd0, dout}, 32'h0F);

    // Framing error, held until the next completed frame
    send_frame(8'hC6, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    check("ferr_hold", {31'd0, frame_err}, 32'h1);
    check("done_count_c6", n_done, exp_done);

    // Good frame 0x12 with a 100-clk tick stall inside the data bits
    fork
      send_frame(8'h12, 1'b1, 1'b1);
      begin
        wait_clk(4 * BIT_CLK + BIT_CLK / 4);
        tick_en = 1'b0;
        done_before = n_done;
        wait_clk(100);
        tick_en = 1'b1;
        check("stall_no_done", n_done, done_before);
      end
    join
    wait_clk(200);
    check("done_count_12", n_done, exp_done);

    // Reset during the 4th data bit of 0xFF
    rx = 1'b0;
    wait_clk(BIT_CLK);
    rx = 1'b1;
    wait_clk(3 * BIT_CLK + BIT_CLK / 2);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(2);
    check("midreset_dout", {24'd0, dout}, 32'h0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'h0);
    wait_clk(BIT_CLK);
    check("midreset_done_count", n_done, exp_done);

    // Recovery frame
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_clk(200);
    check("done_count_final", n_done, exp_done);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
